bus_arbiter_8: RTL

//   Round-robin arbiter for up to eight requesters sharing the tri-stated internal data bus.

---
 rtl/bus_arbiter_8.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter_8.sv
//==============================================================================
// Module      : bus_arbiter_8
// Description : Round-robin arbiter for eight requesters sharing the internal
//               tri-stated data bus. Drives select/en of the 8:1 bus mux and
//               returns a registered one-hot grant. Inserts a one-cycle
//               turnaround between owners and a hold limit against starvation.
//               Optional feature macro: ARB_LOCK_EN (adds the lock input that
//               suppresses hold-limit preemption for atomic sequences).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_arbiter_8 #(
    parameter int MAX_HOLD = 4     // consecutive grant cycles before preemption; 0 = unlimited
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] select,
    output logic       en,
    output logic       busy
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [7:0]        gnt_q;
    logic [2:0]        select_q;
    logic              en_q;
    logic              busy_q;
    logic [2:0]        ptr_q;
    logic [HOLD_W-1:0] hold_q;

    logic              found_d;
    logic [2:0]        win_d;
    logic [2:0]        idx_d;
    logic [7:0]        others_d;
    logic              locked_d;
    logic              preempt_d;

`ifdef ARB_LOCK_EN
    assign locked_d = lock;
`else
    assign locked_d = 1'b0;
`endif

    // Round-robin search: first set request scanning ptr+1 .. ptr+8 (3-bit wrap).
    always_comb begin
        found_d = 1'b0;
        win_d   = ptr_q;
        idx_d   = '0;
        for (int i = 1; i <= 8; i++) begin
            idx_d = ptr_q + 3'(i);
            if (!found_d && req[idx_d]) begin
                found_d = 1'b1;
                win_d   = idx_d;
            end
        end
    end

    // Hold-limit preemption: only when the limit is reached and someone else waits.
    always_comb begin
        others_d  = req & ~(8'h01 << select_q);
        preempt_d = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) &&
                    (others_d != 8'h00) && !locked_d;
    end

    // Arbiter FSM with registered outputs; select/ptr keep the last owner outside GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 8'h00;
            select_q <= 3'd0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= 3'd7;
            hold_q   <= '0;
        end else begin
            case (state_q)
                S_GRANT: begin
                    // A release coinciding with hold expiry is a single TURN either way.
                    if (!req[select_q] || preempt_d) begin
                        state_q <= S_TURN;
                        gnt_q   <= 8'h00;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LIM)) begin
                        hold_q  <= hold_q + 1'b1;
                    end
                end
                S_IDLE, S_TURN: begin
                    if (found_d) begin
                        state_q  <= S_GRANT;
                        ptr_q    <= win_d;
                        select_q <= win_d;
                        gnt_q    <= 8'h01 << win_d;
                        en_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        hold_q   <= HOLD_W'(1);
                    end else begin
                        state_q  <= S_IDLE;
                        gnt_q    <= 8'h00;
                        en_q     <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 8'h00;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign select = select_q;
    assign en     = en_q;
    assign busy   = busy_q;

endmodule

`default_nettype wire
